// File: rtl/coo_to_adj_stream.sv
// coo_to_adj_stream: COO edge stream -> registered NxN adjacency + row degrees.
// Ports: start/num_edges (graph start), edge_* (valid/ready edge stream),
//   adj_mat/deg/edge_count (results), busy/done/err_range (status).
module coo_to_adj_stream #(
   parameter int NUM_NODES  = 6,
   parameter int NODE_W     = 3,
   parameter int MAX_EDGES  = 16,
   parameter int EDGE_CNT_W = 5,
   parameter int DEG_W      = 3,
   parameter int ONE_BASED  = 1,
   parameter int SYMMETRIC  = 1,
   parameter int SELF_LOOPS = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [EDGE_CNT_W-1:0]          num_edges,
   input  logic                           edge_valid,
   output logic                           edge_ready,
   input  logic [NODE_W-1:0]              edge_src,
   input  logic [NODE_W-1:0]              edge_dst,
   output logic [NUM_NODES*NUM_NODES-1:0] adj_mat,
   output logic [NUM_NODES*DEG_W-1:0]     deg,
   output logic [EDGE_CNT_W-1:0]          edge_count,
   output logic                           busy,
   output logic                           done,
   output logic                           err_range
);

   localparam int N = NUM_NODES;
   localparam logic [EDGE_CNT_W-1:0] MAX_E = EDGE_CNT_W'(MAX_EDGES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [EDGE_CNT_W-1:0] lim_q, lim_d;
   logic                  clamp_q, clamp_d;
   logic [N*N-1:0]        adj_q, adj_d;
   logic [N*DEG_W-1:0]    deg_q, deg_d;
   logic [EDGE_CNT_W-1:0] cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   int         si, sj;
   logic       pair_ok;
   logic [N-1:0] row_new;

   // Converted indices; a raw 0 under one-based indexing becomes -1.
   always_comb begin
      si = int'(edge_src) - ONE_BASED;
      sj = int'(edge_dst) - ONE_BASED;
      pair_ok = (si >= 0) && (si < N) && (sj >= 0) && (sj < N);
   end

   always_comb begin
      state_d = state_q;
      lim_d   = lim_q;
      clamp_d = clamp_q;
      adj_d   = adj_q;
      deg_d   = deg_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      row_new = '0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               clamp_d = (num_edges > MAX_E);
               lim_d   = (num_edges > MAX_E) ? MAX_E : num_edges;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            adj_d = '0;
            deg_d = '0;
            cnt_d = '0;
            err_d = clamp_q;
            if (SELF_LOOPS != 0) begin
               for (int r = 0; r < N; r++) begin
                  adj_d[r*N+r] = 1'b1;
                  deg_d[r*DEG_W +: DEG_W] = DEG_W'(1);
               end
            end
            state_d = (lim_q == '0) ? S_DONE : S_LOAD;
         end
         S_LOAD: begin
            if (edge_valid) begin
               cnt_d = cnt_q + EDGE_CNT_W'(1);
               if (!pair_ok) begin
                  err_d = 1'b1;
               end else begin
                  for (int r = 0; r < N; r++) begin
                     for (int c = 0; c < N; c++) begin
                        if ((r == si && c == sj) ||
                            (SYMMETRIC != 0 && r == sj && c == si))
                           adj_d[r*N+c] = 1'b1;
                     end
                  end
                  // At most one bit per row can newly rise per edge.
                  for (int r = 0; r < N; r++) begin
                     row_new = adj_d[r*N +: N] & ~adj_q[r*N +: N];
                     deg_d[r*DEG_W +: DEG_W] =
                        deg_q[r*DEG_W +: DEG_W] + DEG_W'(|row_new);
                  end
               end
               if (cnt_d == lim_q)
                  state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_CLEAR) || (state_d == S_LOAD);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lim_q   <= '0;
         clamp_q <= 1'b0;
         adj_q   <= '0;
         deg_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lim_q   <= lim_d;
         clamp_q <= clamp_d;
         adj_q   <= adj_d;
         deg_q   <= deg_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign edge_ready = (state_q == S_LOAD);
   assign adj_mat    = adj_q;
   assign deg        = deg_q;
   assign edge_count = cnt_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err_range  = err_q;

endmodule

// File: tb/tb_coo_to_adj_stream.sv
// tb_coo_to_adj_stream: drives a default instance and a self-loop instance
// with the same edge streams and compares both against a matrix model.
module tb_coo_to_adj_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  num_edges = '0;
   logic        edge_valid = 1'b0;
   logic [2:0]  edge_src = '0;
   logic [2:0]  edge_dst = '0;

   logic        er_a, busy_a, done_a, err_a;
   logic [35:0] adj_a;
   logic [17:0] deg_a;
   logic [4:0]  ec_a;
   logic        er_b, busy_b, done_b, err_b;
   logic [35:0] adj_b;
   logic [17:0] deg_b;
   logic [4:0]  ec_b;

   int checks = 0;
   int errors = 0;

   bit mdl[2][6][6];
   bit mdl_err;
   int es[$];
   int ed[$];
   int eg[$];

   coo_to_adj_stream dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .num_edges(num_edges),
      .edge_valid(edge_valid), .edge_ready(er_a),
      .edge_src(edge_src), .edge_dst(edge_dst),
      .adj_mat(adj_a), .deg(deg_a), .edge_count(ec_a),
      .busy(busy_a), .done(done_a), .err_range(err_a)
   );

   coo_to_adj_stream #(.SELF_LOOPS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .num_edges(num_edges),
      .edge_valid(edge_valid), .edge_ready(er_b),
      .edge_src(edge_src), .edge_dst(edge_dst),
      .adj_mat(adj_b), .deg(deg_b), .edge_count(ec_b),
      .busy(busy_b), .done(done_b), .err_range(err_b)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [35:0] exp_adj(input int s);
      logic [35:0] v;
      v = '0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            v[r*6+c] = mdl[s][r][c];
      return v;
   endfunction

   function automatic logic [17:0] exp_deg(input int s);
      logic [17:0] v;
      int cnt;
      v = '0;
      for (int r = 0; r < 6; r++) begin
         cnt = 0;
         for (int c = 0; c < 6; c++)
            cnt += int'(mdl[s][r][c]);
         v[r*3 +: 3] = 3'(cnt);
      end
      return v;
   endfunction

   task automatic model_clear(input bit clamp);
      for (int s = 0; s < 2; s++)
         for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
               mdl[s][r][c] = (s == 1) && (r == c);
      mdl_err = clamp;
   endtask

   task automatic model_edge(input int s, input int d);
      if (s >= 1 && s <= 6 && d >= 1 && d <= 6) begin
         for (int x = 0; x < 2; x++) begin
            mdl[x][s-1][d-1] = 1'b1;
            mdl[x][d-1][s-1] = 1'b1;
         end
      end else begin
         mdl_err = 1'b1;
      end
   endtask

   task automatic drive_graph(input int n, input string nm);
      int lim;
      lim = (n > 16) ? 16 : n;
      start = 1'b1;
      num_edges = 5'(n);
      tick();
      start = 1'b0;
      checks++;
      if (busy_a !== 1'b1 || busy_b !== 1'b1 || er_a !== 1'b0 ||
          done_a !== 1'b0) begin
         errors++;
         $display("FAIL %s clear: busy=%b ready=%b done=%b want 1 0 0",
                  nm, busy_a, er_a, done_a);
      end
      model_clear(n > 16);
      tick();
      checks++;
      if (adj_a !== exp_adj(0) || adj_b !== exp_adj(1) || ec_a !== 5'd0 ||
          err_a !== mdl_err || err_b !== mdl_err) begin
         errors++;
         $display("FAIL %s cleared: adj=%h/%h cnt=%0d err=%b want %h/%h 0 %b",
                  nm, adj_a, adj_b, ec_a, err_a, exp_adj(0), exp_adj(1),
                  mdl_err);
      end
      checks++;
      if (done_a !== (lim == 0) || done_b !== (lim == 0) ||
          er_a !== (lim != 0) || er_b !== (lim != 0)) begin
         errors++;
         $display("FAIL %s entry: done=%b ready=%b want %b %b",
                  nm, done_a, er_a, lim == 0, lim != 0);
      end
      for (int k = 0; k < lim; k++) begin
         for (int g = 0; g < eg[k]; g++) begin
            edge_valid = 1'b0;
            start = 1'b1;
            edge_src = 3'($urandom);
            tick();
            checks++;
            if (er_a !== 1'b1 || er_b !== 1'b1 || ec_a !== 5'(k) ||
                ec_b !== 5'(k)) begin
               errors++;
               $display("FAIL %s stall%0d: ready=%b cnt=%0d want 1 %0d",
                        nm, k, er_a, ec_a, k);
            end
         end
         start = 1'b0;
         edge_valid = 1'b1;
         edge_src = 3'(es[k]);
         edge_dst = 3'(ed[k]);
         tick();
         model_edge(es[k], ed[k]);
         checks++;
         if (ec_a !== 5'(k+1) || ec_b !== 5'(k+1) ||
             adj_a !== exp_adj(0) || adj_b !== exp_adj(1) ||
             err_a !== mdl_err || err_b !== mdl_err) begin
            errors++;
            $display("FAIL %s xfer%0d: cnt=%0d adj=%h/%h err=%b want %0d %h/%h %b",
                     nm, k, ec_a, adj_a, adj_b, err_a, k+1,
                     exp_adj(0), exp_adj(1), mdl_err);
         end
         checks++;
         if (done_a !== (k == lim-1) || done_b !== (k == lim-1) ||
             er_a !== (k != lim-1)) begin
            errors++;
            $display("FAIL %s done_timing%0d: done=%b ready=%b want %b %b",
                     nm, k, done_a, er_a, k == lim-1, k != lim-1);
         end
      end
      edge_valid = 1'b0;
      checks++;
      if (deg_a !== exp_deg(0) || deg_b !== exp_deg(1) || busy_a !== 1'b0 ||
          done_a !== 1'b1 || done_b !== 1'b1) begin
         errors++;
         $display("FAIL %s final: deg=%o/%o busy=%b done=%b want %o/%o 0 1",
                  nm, deg_a, deg_b, busy_a, done_a, exp_deg(0), exp_deg(1));
      end
      tick();
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || er_a !== 1'b0 ||
          adj_a !== exp_adj(0) || adj_b !== exp_adj(1) ||
          deg_b !== exp_deg(1)) begin
         errors++;
         $display("FAIL %s idle_hold: done=%b busy=%b ready=%b adj=%h want 0 0 0 %h",
                  nm, done_a, busy_a, er_a, adj_a, exp_adj(0));
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({adj_a, deg_a, ec_a, busy_a, done_a, err_a, er_a} !== '0 ||
          {adj_b, deg_b, ec_b, busy_b, done_b, err_b, er_b} !== '0) begin
         errors++;
         $display("FAIL reset: adj=%h deg=%o cnt=%0d flags=%b%b%b%b want 0",
                  adj_b, deg_b, ec_a, busy_a, done_a, err_a, er_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      logic [5:0]  rows[6];
      logic [17:0] da, db;
      int          ga[6];
      int          gb[6];
      rows = '{6'b000110, 6'b001001, 6'b001001,
               6'b010110, 6'b101000, 6'b010000};
      ga = '{2, 2, 2, 3, 2, 1};
      gb = '{3, 3, 3, 4, 3, 2};
      es = '{1, 1, 2, 3, 4, 5};
      ed = '{2, 3, 4, 4, 5, 6};
      eg = '{0, 0, 0, 0, 0, 0};
      drive_graph(6, "basic");
      for (int r = 0; r < 6; r++) begin
         checks++;
         if (adj_a[r*6 +: 6] !== rows[r] ||
             adj_b[r*6 +: 6] !== (rows[r] | (6'b1 << r))) begin
            errors++;
            $display("FAIL basic_row%0d: got %b/%b want %b",
                     r, adj_a[r*6 +: 6], adj_b[r*6 +: 6], rows[r]);
         end
      end
      da = '0;
      db = '0;
      for (int r = 0; r < 6; r++) begin
         da[r*3 +: 3] = 3'(ga[r]);
         db[r*3 +: 3] = 3'(gb[r]);
      end
      checks++;
      if (deg_a !== da || deg_b !== db || err_a !== 1'b0) begin
         errors++;
         $display("FAIL basic_deg: got %o/%o err=%b want %o/%o 0",
                  deg_a, deg_b, err_a, da, db);
      end
   endtask

   task automatic test_self_loop_extra;
      logic [35:0] prev_b;
      logic [17:0] prev_db;
      prev_b  = adj_b;
      prev_db = deg_b;
      es = '{1, 1, 2, 3, 4, 5, 3};
      ed = '{2, 3, 4, 4, 5, 6, 3};
      eg = '{0, 0, 0, 0, 0, 0, 0};
      drive_graph(7, "selfloop");
      checks++;
      if (adj_b !== prev_b || deg_b !== prev_db) begin
         errors++;
         $display("FAIL selfloop_extra: adj=%h deg=%o want %h %o",
                  adj_b, deg_b, prev_b, prev_db);
      end
   endtask

   task automatic test_duplicates;
      es = '{1, 2, 1};
      ed = '{2, 1, 2};
      eg = '{0, 0, 0};
      drive_graph(3, "dup");
      checks++;
      if (adj_a !== 36'h42 || deg_a !== 18'o11 || ec_a !== 5'd3) begin
         errors++;
         $display("FAIL dup: adj=%h deg=%o cnt=%0d want 42 11 3",
                  adj_a, deg_a, ec_a);
      end
   endtask

   task automatic test_range;
      es = '{0, 7};
      ed = '{2, 1};
      eg = '{0, 0};
      drive_graph(2, "range");
      checks++;
      if (adj_a !== '0 || err_a !== 1'b1 || ec_a !== 5'd2) begin
         errors++;
         $display("FAIL range: adj=%h err=%b cnt=%0d want 0 1 2",
                  adj_a, err_a, ec_a);
      end
   endtask

   task automatic test_stall;
      es = '{1, 2};
      ed = '{4, 5};
      eg = '{0, 2};
      drive_graph(2, "stall");
   endtask

   task automatic test_clamp;
      es = {};
      ed = {};
      eg = {};
      for (int k = 0; k < 16; k++) begin
         es.push_back(int'($urandom_range(1, 6)));
         ed.push_back(int'($urandom_range(1, 6)));
         eg.push_back(0);
      end
      drive_graph(20, "clamp");
      checks++;
      if (err_a !== 1'b1 || ec_a !== 5'd16) begin
         errors++;
         $display("FAIL clamp: err=%b cnt=%0d want 1 16", err_a, ec_a);
      end
   endtask

   task automatic test_reset_mid;
      start = 1'b1;
      num_edges = 5'd6;
      tick();
      start = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         edge_valid = 1'b1;
         edge_src = 3'(k + 1);
         edge_dst = 3'(k + 2);
         tick();
      end
      edge_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({adj_a, deg_a, ec_a, busy_a, done_a, err_a, er_a} !== '0 ||
          {adj_b, deg_b, ec_b, busy_b, done_b, err_b, er_b} !== '0) begin
         errors++;
         $display("FAIL reset_mid: adj=%h/%h cnt=%0d busy=%b want 0",
                  adj_a, adj_b, ec_a, busy_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      es = {};
      ed = {};
      eg = {};
      drive_graph(0, "zero");
      checks++;
      if (adj_a !== '0 || ec_a !== 5'd0) begin
         errors++;
         $display("FAIL zero_adj: adj=%h cnt=%0d want 0 0", adj_a, ec_a);
      end
   endtask

   task automatic test_random;
      int n;
      for (int t = 0; t < 15; t++) begin
         n = int'($urandom_range(0, 16));
         es = {};
         ed = {};
         eg = {};
         for (int k = 0; k < n; k++) begin
            es.push_back(int'($urandom_range(0, 7)));
            ed.push_back(int'($urandom_range(0, 7)));
            eg.push_back(($urandom_range(0, 3) == 0) ?
                         int'($urandom_range(1, 2)) : 0);
         end
         drive_graph(n, "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_self_loop_extra();
      test_duplicates();
      test_range();
      test_stall();
      test_clamp();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/coo_to_adj_stream.md
Name: coo_to_adj_stream

Overview:
- Parametrised successor to the fixed 6-node COO converter: accepts a COO edge list as a valid/ready stream, one edge per cycle, and builds a registered NxN adjacency matrix plus per-node degree counts.
- Configurable indexing base, symmetric or directed mode, optional self-loop insertion (A+I for GCN normalisation), and out-of-range edge detection.
- Sits between the graph loader and the GCN aggregation/normalisation stage.

Parameters:
- NUM_NODES, 6, node count N.
- NODE_W, 3, bits per node index on edge_src/edge_dst.
- MAX_EDGES, 16, maximum edges per graph.
- EDGE_CNT_W, 5, width of edge counters; must be at least $clog2(MAX_EDGES+1).
- DEG_W, 3, degree width per node; must be at least $clog2(NUM_NODES+1).
- ONE_BASED, 1, 1 = incoming indices are 1..N; 0 = indices are 0..N-1.
- SYMMETRIC, 1, 1 = edge (i,j) also sets (j,i).
- SELF_LOOPS, 0, 1 = diagonal is preset to 1 at graph start.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new graph; sampled in IDLE only.
- num_edges  input  EDGE_CNT_W  edge count for this graph; latched on start.
- edge_valid  input  1  edge_src/edge_dst are valid.
- edge_ready  output  1  block accepts an edge this cycle.
- edge_src  input  NODE_W  source node index.
- edge_dst  input  NODE_W  destination node index.
- adj_mat  output  N*N  flattened row-major matrix; bit r*N+c is A[r][c].
- deg  output  N*DEG_W  row degree (popcount of row r) at bits r*DEG_W +: DEG_W.
- edge_count  output  EDGE_CNT_W  edges accepted so far in this graph.
- busy  output  1  high in CLEAR and LOAD.
- done  output  1  one-cycle pulse when the matrix is complete.
- err_range  output  1  sticky error flag; cleared in CLEAR.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. adj_mat, deg, edge_count, busy, done, err_range and edge_ready all go to 0.
- FSM states: IDLE, CLEAR, LOAD, DONE. All outputs are registered, except edge_ready = (state==LOAD).
- IDLE:
  - start=1 latches num_edges and moves to CLEAR.
  - If num_edges > MAX_EDGES: clamp the latched value to MAX_EDGES and set err_range in CLEAR.
  - start asserted in any other state is ignored.
- CLEAR (1 cycle):
  - adj_mat <= 0, deg <= 0, edge_count <= 0, err_range <= 0 (or 1 per the clamp rule above).
  - If SELF_LOOPS=1: diagonal bits <= 1 and every deg <= 1.
  - Next state is LOAD; if the latched count is 0, next state is DONE.
- LOAD:
  - An edge transfers on edge_valid && edge_ready. While edge_valid=0 the block waits indefinitely.
  - Index conversion: i = edge_src - ONE_BASED, j = edge_dst - ONE_BASED.
  - Range check: when ONE_BASED=1, raw 0 is invalid; any converted index >= N is invalid.
  - Invalid edge: matrix unchanged, err_range <= 1, edge still counted.
  - Valid edge: set A[i][j]. If SYMMETRIC=1 and i!=j, also set A[j][i].
  - deg[r] increments only on a 0->1 transition of a bit in row r. Duplicate edges, reversed duplicates and self-loops already present do not change deg.
  - Each transfer increments edge_count.
  - The transfer that makes edge_count equal the latched count moves the FSM to DONE; edge_ready is 0 from the next cycle.
- DONE (1 cycle): done=1, busy=0, then IDLE. adj_mat and deg hold until the next start reaches CLEAR.
- Latency: start sampled at cycle T; CLEAR at T+1; first edge can transfer at T+2. With edge_valid held high, edge k (1-based) transfers at T+1+k and done is high at T+2+num_edges. The final matrix is visible in the same cycle done is high.
- Width rules: deg never exceeds N by construction, so no saturation logic is needed. edge_count never exceeds MAX_EDGES.
- Reset mid-LOAD: immediate return to reset values; the partial matrix is discarded.

Test Plan:
- Defaults; start with num_edges=6; edges (1,2)(1,3)(2,4)(3,4)(4,5)(5,6) streamed back-to-back.
  -> done at T+8.
  -> rows: 0:0b000110, 1:0b001001, 2:0b001001, 3:0b010110, 4:0b101000, 5:0b010000 (bit c = column c).
  -> deg = 2,2,2,3,2,1; err_range=0.
- SELF_LOOPS=1, same edges.
  -> all diagonal bits 1; deg = 3,3,3,4,3,2.
  -> an extra edge (3,3) changes nothing.
- Edges (1,2),(2,1),(1,2) with num_edges=3.
  -> only A[0][1]=A[1][0]=1; deg0=deg1=1; edge_count=3.
- Edge (0,2) then (7,1), ONE_BASED=1.
  -> both dropped; err_range=1 after the first; adj_mat=0; done still fires after 2 transfers.
- edge_valid toggled 1,0,0,1 across 2 edges.
  -> edge_ready stays high; exactly 2 transfers; done one cycle after the second.
- rst_n pulsed low mid-LOAD after 3 of 6 edges.
  -> all outputs 0 immediately.
  -> a fresh start with num_edges=0 gives done at T+2 with adj_mat=0.
